io_handshake_unit: RTL

//  Parametrised successor to the processor's switch/OK/7-segment I/O path.

---
 rtl/io_handshake_if.sv | 28 ++
 rtl/io_handshake_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/io_handshake_if.sv
// Handshake/bus signals between the core datapath, the board pins and
// io_handshake_unit. The core/board side uses the master modport and the
// unit uses the slave modport.
interface io_handshake_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BUS_W    = 15,
  parameter int unsigned N_DIGITS = 4
);
  logic                  in_req;
  logic                  out_req;
  logic [DATA_W-1:0]     out_data;
  logic [BUS_W-1:0]      bus_in;
  logic                  ok_n;
  logic                  stall;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic [7*N_DIGITS-1:0] hex;

  modport master (
    output in_req, out_req, out_data, bus_in, ok_n,
    input  stall, in_valid, in_data, hex
  );

  modport slave (
    input  in_req, out_req, out_data, bus_in, ok_n,
    output stall, in_valid, in_data, hex
  );
endinterface

// File: rtl/io_handshake_unit.sv
// io_handshake_unit: serves IN/OUT instructions for the single-cycle core.
//  IN  : stalls the core until OK is pressed and released, then returns the
//        zero-extended switch bus with a one-cycle in_valid pulse.
//  OUT : latches out_data onto N_DIGITS active-low 7-segment digits.
// Build option IO_DEBOUNCE_EN: when defined, OK edges must be stable for
// DEBOUNCE_CYCLES cycles; when undefined, the synchronised key is used as-is.
module io_handshake_unit #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned BUS_W           = 15,
  parameter int unsigned N_DIGITS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic          clock,
  input  logic          reset,
  io_handshake_if.slave io
);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_ok_stable;
  logic                  w_toggle;
  logic                  w_press;
  logic                  w_release;
  logic                  w_capture;
  logic [DATA_W-1:0]     r_in_data;
  logic [4*N_DIGITS-1:0] r_disp;
  logic                  w_unused;

  // Two-flop synchroniser for the asynchronous OK key (released = 1)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= io.ok_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             r_ok_stable;
  logic [CNT_W-1:0] r_cnt;

  assign w_toggle    = (r_sync2 != r_ok_stable) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_ok_stable = r_ok_stable;
  assign w_unused    = ^io.out_data;

  // Debounce: count consecutive cycles the synchronised key differs from the
  // stable level; flip the stable level on the last counted cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ok_stable <= 1'b1;
      r_cnt       <= '0;
    end else if (r_sync2 == r_ok_stable) begin
      r_cnt       <= '0;
    end else if (w_toggle) begin
      r_ok_stable <= r_sync2;
      r_cnt       <= '0;
    end else begin
      r_cnt       <= r_cnt + CNT_W'(1);
    end
  end
`else
  // Stable level is the synchroniser output; an edge is reported in the same
  // cycle the second flop is about to take the new value.
  assign w_toggle    = (r_sync1 != r_sync2);
  assign w_ok_stable = r_sync2;
  assign w_unused    = ^{io.out_data, 32'(DEBOUNCE_CYCLES)};
`endif

  assign w_press   = w_toggle &  w_ok_stable;
  assign w_release = w_toggle & ~w_ok_stable;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state, capture strobe, stall and in_valid
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    io.stall    = 1'b0;
    io.in_valid = 1'b0;
    case (r_state)
      IDLE: begin
        io.stall = reset & io.in_req;
        if (io.in_req) w_state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        io.stall = reset;
        if (!io.in_req) begin
          w_state_nxt = IDLE;
        end else if (w_press) begin
          w_capture   = 1'b1;
          w_state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        io.stall = reset;
        if (!io.in_req)     w_state_nxt = IDLE;
        else if (w_release) w_state_nxt = DONE;
      end
      DONE: begin
        io.in_valid = reset;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Switch capture on the accepted press
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_in_data <= '0;
    else if (w_capture) r_in_data <= DATA_W'(io.bus_in);
  end

  assign io.in_data = r_in_data;

  // Display register, loaded by OUT independently of the IN handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_disp <= '0;
    else if (io.out_req) r_disp <= io.out_data[4*N_DIGITS-1:0];
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Per-digit hex decode of the display register
  always_comb begin
    io.hex = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      io.hex[7*i +: 7] = seg7(r_disp[4*i +: 4]);
    end
  end

endmodule
